weighted_sum_accumulator: RTL and testbench

- Downstream consumer of the weighted adder/multiplier stage.
- Takes the 16-bit combined {overflow,y} product word one sample at a time under a valid/ready handshake.
- Accumulates COUNT samples, or fewer if flushed early, into a saturating unsigned sum.
- Presents each completed frame result on a held valid/ready output port.

---
 rtl/weighted_sum_accumulator_if.sv | 27 ++
 rtl/weighted_sum_accumulator.sv | 104 ++++++++++
 tb/tb_weighted_sum_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/weighted_sum_accumulator_if.sv
// Handshake bundle between the weighted product stage, the frame accumulator and its consumer.
// The master modport is the side that feeds samples and takes results; the slave modport is the accumulator.
interface weighted_sum_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/weighted_sum_accumulator.sv
// Frame accumulator: sums up to COUNT unsigned product words into a saturating total,
// closes the frame on the COUNT-th sample or on an early flush, and holds the result until taken.
module weighted_sum_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24,
    parameter int COUNT = 4,
    parameter int CNT_W = 3
) (
    input logic clk,
    input logic rst,
    weighted_sum_accumulator_if.slave bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next, acc_upd;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_upd;
    logic             sat, sat_next, sat_upd;
    logic [ACC_W:0]   add_res;
    logic             accept, close, ready_int;
    logic [ACC_W-1:0] sum_reg;
    logic [CNT_W-1:0] count_reg;
    logic             sat_reg;

    // Returns {overflow, value}; value clamps to all ones when the carry out is set.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [IN_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
        if (s[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

    assign ready_int = (state == ACCUM) && !rst;
    assign accept    = bus.in_valid && ready_int;
    assign add_res   = sat_add(acc, bus.in_data);

    always_comb begin
        acc_upd    = acc;
        cnt_upd    = cnt;
        sat_upd    = sat;
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat;
        close      = 1'b0;
        if (accept) begin
            acc_upd = add_res[ACC_W-1:0];
            cnt_upd = cnt + CNT_W'(1);
            sat_upd = sat | add_res[ACC_W];
        end
        case (state)
            ACCUM: begin
                acc_next = acc_upd;
                cnt_next = cnt_upd;
                sat_next = sat_upd;
                // An empty frame is never closed, even on flush.
                close = (accept && (cnt_upd == CNT_W'(COUNT))) ||
                        (bus.flush && (cnt_upd != '0));
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            sum_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            sat   <= sat_next;
            if (close) begin
                sum_reg   <= acc_upd;
                count_reg <= cnt_upd;
                sat_reg   <= sat_upd;
            end
        end
    end

    assign bus.in_ready  = ready_int;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_reg;
    assign bus.out_count = count_reg;
    assign bus.out_sat   = sat_reg;
endmodule

// File: tb/tb_weighted_sum_accumulator.sv
// Directed bench for weighted_sum_accumulator: vector table on a 24-bit instance plus
// a hand-written saturation sequence on a 17-bit instance.
module tb_weighted_sum_accumulator;
    localparam int IN_W  = 16;
    localparam int ACC_W = 24;
    localparam int COUNT = 4;
    localparam int CNT_W = 3;
    localparam int SAT_W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_s;

    weighted_sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    weighted_sum_accumulator_if #(.IN_W(IN_W), .ACC_W(SAT_W), .CNT_W(CNT_W)) bus_s ();

    weighted_sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(COUNT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    weighted_sum_accumulator #(.IN_W(IN_W), .ACC_W(SAT_W), .COUNT(COUNT), .CNT_W(CNT_W)) dut_s (
        .clk(clk),
        .rst(rst_s),
        .bus(bus_s.slave)
    );

    typedef struct {
        logic              v;
        logic [IN_W-1:0]   d;
        logic              f;
        logic              ordy;
        logic              r;
        logic              e_ov;
        logic              e_ir;
        logic [ACC_W-1:0]  e_sum;
        logic [CNT_W-1:0]  e_cnt;
        logic              e_sat;
        logic              chk;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(input logic v, input logic [IN_W-1:0] d, input logic f,
                                input logic ordy, input logic r, input logic e_ov, input logic e_ir,
                                input logic [ACC_W-1:0] e_sum, input logic [CNT_W-1:0] e_cnt,
                                input logic e_sat, input logic chk);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.ordy = ordy; t.r = r;
        t.e_ov = e_ov; t.e_ir = e_ir; t.e_sum = e_sum; t.e_cnt = e_cnt; t.e_sat = e_sat; t.chk = chk;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_s(input logic v, input logic [IN_W-1:0] d, input logic ordy);
        bus_s.in_valid  = v;
        bus_s.in_data   = d;
        bus_s.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle accept rows: valid sample, still accumulating
        // columns: v, d, f, ordy, r | ov, ir, sum, cnt, sat, chk
        // nominal
        add(1, 16'h000A, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h000A, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h000A, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h000A, 0, 0, 0, 1, 0, 24'h28, 4, 0, 1);
        add(1, 16'h000A, 0, 0, 0, 1, 0, 24'h28, 4, 0, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // gapped input
        add(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0004, 0, 0, 0, 1, 0, 24'h0A, 4, 0, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // early flush alone, then flush on empty frame
        add(1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0007, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 1, 0, 24'd10, 2, 0, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // flush together with the third accept
        add(1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0007, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0005, 1, 0, 0, 1, 0, 24'd15, 3, 0, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // backpressure with in_valid held and a flush during HOLD
        add(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0001, 0, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 0, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 1, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 0, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 0, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 0, 0, 0, 1, 0, 24'd4, 4, 0, 1);
        add(1, 16'h0055, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0010, 0, 0, 0, 1, 0, 24'h40, 4, 0, 1);
        add(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // reset mid-frame, then a clean frame
        add(1, 16'h0030, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0030, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 16'h0002, 0, 0, 0, 1, 0, 24'd8, 4, 0, 1);
        // reset while holding a result
        add(0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        rst = 1'b1;
        rst_s = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.flush = 1'b0; bus_s.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_s = 1'b0;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_sum", 32'(bus.out_sum), 32'd0);
        check("reset out_count", 32'(bus.out_count), 32'd0);
        check("reset out_sat", 32'(bus.out_sat), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_valid  = vecs[i].v;
            bus.in_data   = vecs[i].d;
            bus.flush     = vecs[i].f;
            bus.out_ready = vecs[i].ordy;
            rst           = vecs[i].r;
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
            if (vecs[i].chk) begin
                check($sformatf("row%0d out_sum", i), 32'(bus.out_sum), 32'(vecs[i].e_sum));
                check($sformatf("row%0d out_count", i), 32'(bus.out_count), 32'(vecs[i].e_cnt));
                check($sformatf("row%0d out_sat", i), 32'(bus.out_sat), 32'(vecs[i].e_sat));
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;

        // saturation on the 17-bit instance
        for (int i = 0; i < 3; i++) begin
            step_s(1'b1, 16'hFFFF, 1'b0);
            check($sformatf("sat accept%0d in_ready", i), 32'(bus_s.in_ready), 32'd1);
        end
        step_s(1'b1, 16'hFFFF, 1'b0);
        check("sat out_valid", 32'(bus_s.out_valid), 32'd1);
        check("sat out_sum", 32'(bus_s.out_sum), 32'h1FFFF);
        check("sat out_count", 32'(bus_s.out_count), 32'd4);
        check("sat out_sat", 32'(bus_s.out_sat), 32'd1);
        step_s(1'b0, 16'h0000, 1'b1);
        check("sat release out_valid", 32'(bus_s.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step_s(1'b1, 16'h0001, 1'b0);
        end
        check("post-sat out_valid", 32'(bus_s.out_valid), 32'd1);
        check("post-sat out_sum", 32'(bus_s.out_sum), 32'd4);
        check("post-sat out_count", 32'(bus_s.out_count), 32'd4);
        check("post-sat out_sat", 32'(bus_s.out_sat), 32'd0);
        step_s(1'b0, 16'h0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
